mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the byte-serial RAM bus driven by the memory controller.
- Provides one byte per access with a registered read of 1-cycle latency.
- Decodes an IO window: UART transmit FIFO, receive holding byte, status register and halt register.
- Drives io_buffer_full back to the controller. Sits between the controller and the board RAM/UART.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width; RAM holds 2^ADDR_WIDTH bytes.
- TX_DEPTH, 8, UART transmit FIFO depth in bytes (power of two, at least 4).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-low
- rdy_in  input  1  global enable; when 0, all state is frozen
- mem_wr_i  input  1  1 = write cycle, 0 = read cycle
- mem_addr_i  input  32  byte address
- mem_wr_data_i  input  8  write byte
- mem_rd_data_o  output  8  read byte, valid the cycle after the address
- io_buffer_full_o  output  1  TX FIFO nearly full
- uart_tx_valid_o  output  1  TX FIFO not empty
- uart_tx_data_o  output  8  TX FIFO head byte
- uart_tx_ready_i  input  1  UART accepts head byte
- uart_rx_valid_i  input  1  received byte strobe
- uart_rx_data_i  input  8  received byte
- halt_o  output  1  sticky program-end flag
- err_o  output  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (rst_in=0, asynchronous) clears: mem_rd_data_o=0x00, io_buffer_full_o=0, uart_tx_valid_o=0, uart_tx_data_o=0x00, halt_o=0, err_o=0; TX FIFO empty; RX holding register empty.
- RAM contents are not cleared. Reset during a multi-byte access simply abandons it.
- All state advances on the rising clk_in edge only when rdy_in=1; otherwise all registers hold.
- Region select: IO when mem_addr_i[17:16]==2'b11, else RAM. RAM index is mem_addr_i[ADDR_WIDTH-1:0].
- RAM read:
  - Address sampled at edge N; mem_rd_data_o = mem[addr] after edge N.
  - Back-to-back reads at consecutive addresses stream one byte per cycle.
- RAM write: mem[addr] <= mem_wr_data_i at edge N; mem_rd_data_o holds its previous value.
- IO 0x30000 write: push byte into TX FIFO. If the FIFO is full, the byte is dropped; no other effect.
- IO 0x30000 read:
  - mem_rd_data_o = RX byte if present, else 0x00; RX register is cleared.
  - Simultaneous uart_rx_valid_i: old byte is returned, new byte is loaded.
- IO 0x30004 read: mem_rd_data_o = {6'b0, tx_full, rx_present}.
- IO 0x30004 write: halt_o <= 1, sticky until reset.
- Other IO addresses: reads return 0x00, writes are ignored.
- RX: uart_rx_valid_i loads the register when empty; it is dropped when the register is full and not being read that cycle.
- TX FIFO:
  - Circular buffer; read/write pointers wrap at TX_DEPTH; separate count register, range 0..TX_DEPTH.
  - uart_tx_valid_o = (count!=0); uart_tx_data_o = head byte; pop on valid && ready.
  - Simultaneous push and pop: both occur and count is unchanged, including at count==TX_DEPTH.
- io_buffer_full_o is registered: 1 when next count >= TX_DEPTH-1. The one-slot margin covers the controller's one-cycle sampling lag.

Optional Feature:
- Macro MEM_RESP_OOB_CHECK_EN.
- Defined:
  - An access with mem_addr_i[31:18] != 0 sets err_o (sticky until reset).
  - That access is suppressed: no write, no FIFO push, and mem_rd_data_o = 0x00.
- Undefined:
  - Upper address bits are ignored and addresses alias into RAM/IO.
  - err_o is tied to 0.

Decomposition:
- Shared package/def include holds:
  - IO_REGION select value 2'b11
  - IO_DATA_ADDR = 32'h30000
  - IO_STAT_ADDR = 32'h30004
  - status bit positions
  - default TX_DEPTH
- Natural sub-module: byte_fifo (parameterised depth, push/pop, count, full/empty, near-full), instantiated for TX.
- RAM array and IO decode stay in mem_responder.

Test Plan:
- Write 0x11,0x22,0x33,0x44 to 0x100..0x103, then read 0x100..0x103 back-to-back -> mem_rd_data_o = 0x11,0x22,0x33,0x44 on the 4 cycles following each address.
- With uart_tx_ready_i=0, write 0x41 to 0x30000 eight times:
  - io_buffer_full_o rises after the 7th push.
  - The 9th write is dropped.
  - Raising ready drains exactly 8 bytes and uart_tx_valid_o then falls.
- FIFO full with push and pop in the same cycle -> count stays 8 and the FIFO order is preserved across pointer wrap.
- Pulse uart_rx_valid_i with 0x5A:
  - Read 0x30004 -> 0x01.
  - Read 0x30000 -> 0x5A.
  - Read 0x30004 -> 0x00.
- Write 0x30004 -> halt_o=1. Assert rst_in=0 mid-stream -> all outputs reset asynchronously and RAM still returns previously written bytes.
- rdy_in=0 during a write to 0x200 -> memory unchanged and outputs hold. With MEM_RESP_OOB_CHECK_EN, a read of 0x0004_0000 -> err_o=1 and data 0x00.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the byte-serial memory responder: IO window decode and status layout.
package mem_responder_pkg;

    localparam logic [1:0]  IO_REGION        = 2'b11;
    localparam logic [31:0] IO_DATA_ADDR     = 32'h0003_0000;
    localparam logic [31:0] IO_STAT_ADDR     = 32'h0003_0004;
    localparam int unsigned STAT_RX_BIT      = 0;
    localparam int unsigned STAT_TX_FULL_BIT = 1;
    localparam int unsigned DEFAULT_TX_DEPTH = 8;

    typedef enum logic [1:0] {
        IoNone,
        IoData,
        IoStat
    } io_sel_e;

    // Only the low 18 bits take part in IO decode; upper bits alias or are range-checked.
    function automatic io_sel_e decode_io(input logic [17:0] addr);
        if (addr == IO_DATA_ADDR[17:0]) begin
            return IoData;
        end else if (addr == IO_STAT_ADDR[17:0]) begin
            return IoStat;
        end
        return IoNone;
    endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Circular byte FIFO with separate count, registered near-full flag and show-ahead head byte.
module mem_responder_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_near_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_near_full;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_count_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push  = i_push && (!w_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_near_full <= 1'b0;
        end else if (i_en) begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count     <= w_count_next;
            r_near_full <= (w_count_next >= CNT_W'(DEPTH - 1));
        end
    end

    assign o_data      = r_buf[r_rd_ptr];
    assign o_valid     = !w_empty;
    assign o_full      = w_full;
    assign o_near_full = r_near_full;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte RAM with 1-cycle registered read plus UART/status/halt IO window.
// Optional upper-address range check is enabled with MEM_RESP_OOB_CHECK_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = DEFAULT_TX_DEPTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  mem_wr_data_i,
    output logic [7:0]  mem_rd_data_o,
    output logic        io_buffer_full_o,
    output logic        uart_tx_valid_o,
    output logic [7:0]  uart_tx_data_o,
    input  logic        uart_tx_ready_i,
    input  logic        uart_rx_valid_i,
    input  logic [7:0]  uart_rx_data_i,
    output logic        halt_o,
    output logic        err_o
);

    logic [7:0]            r_mem [2**ADDR_WIDTH];
    logic [7:0]            r_rd_data;
    logic                  r_rx_present;
    logic [7:0]            r_rx_data;
    logic                  r_halt;

    logic                  w_oob;
    logic                  w_is_io;
    io_sel_e               w_io_sel;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_we;
    logic                  w_tx_push;
    logic                  w_tx_full;
    logic                  w_rx_read;
    logic                  w_halt_set;
    logic [7:0]            w_status;
    logic [7:0]            w_rd_data_next;
    logic                  w_rx_present_next;
    logic [7:0]            w_rx_data_next;

`ifdef MEM_RESP_OOB_CHECK_EN
    logic r_err;

    assign w_oob = |mem_addr_i[31:18];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_err <= 1'b0;
        end else if (rdy_in && w_oob) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_upper_addr;

    assign w_oob               = 1'b0;
    assign w_unused_upper_addr = ^mem_addr_i[31:18];
    assign err_o               = 1'b0;
`endif

    assign w_is_io    = (mem_addr_i[17:16] == IO_REGION);
    assign w_io_sel   = w_is_io ? decode_io(mem_addr_i[17:0]) : IoNone;
    assign w_ram_idx  = mem_addr_i[ADDR_WIDTH-1:0];
    assign w_ram_we   = mem_wr_i && !w_is_io && !w_oob;
    assign w_tx_push  = mem_wr_i && (w_io_sel == IoData) && !w_oob;
    assign w_rx_read  = !mem_wr_i && (w_io_sel == IoData) && !w_oob;
    assign w_halt_set = mem_wr_i && (w_io_sel == IoStat) && !w_oob;

    always_comb begin
        w_status                   = '0;
        w_status[STAT_RX_BIT]      = r_rx_present;
        w_status[STAT_TX_FULL_BIT] = w_tx_full;
    end

    // Writes leave the read register untouched; reads always update it.
    always_comb begin
        w_rd_data_next = r_rd_data;
        if (!mem_wr_i) begin
            if (w_oob) begin
                w_rd_data_next = 8'h00;
            end else if (w_is_io) begin
                unique case (w_io_sel)
                    IoData:  w_rd_data_next = r_rx_present ? r_rx_data : 8'h00;
                    IoStat:  w_rd_data_next = w_status;
                    default: w_rd_data_next = 8'h00;
                endcase
            end else begin
                w_rd_data_next = r_mem[w_ram_idx];
            end
        end
    end

    // A strobe coinciding with a read refills the holding register after the old byte leaves.
    always_comb begin
        w_rx_present_next = r_rx_present;
        w_rx_data_next    = r_rx_data;
        if (w_rx_read) begin
            w_rx_present_next = uart_rx_valid_i;
            if (uart_rx_valid_i) begin
                w_rx_data_next = uart_rx_data_i;
            end
        end else if (uart_rx_valid_i && !r_rx_present) begin
            w_rx_present_next = 1'b1;
            w_rx_data_next    = uart_rx_data_i;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_ram_we) begin
            r_mem[w_ram_idx] <= mem_wr_data_i;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_data    <= 8'h00;
            r_rx_present <= 1'b0;
            r_rx_data    <= 8'h00;
            r_halt       <= 1'b0;
        end else if (rdy_in) begin
            r_rd_data    <= w_rd_data_next;
            r_rx_present <= w_rx_present_next;
            r_rx_data    <= w_rx_data_next;
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
        end
    end

    mem_responder_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk       (clk_in),
        .i_rst_n     (rst_in),
        .i_en        (rdy_in),
        .i_push      (w_tx_push),
        .i_data      (mem_wr_data_i),
        .i_pop       (uart_tx_ready_i),
        .o_data      (uart_tx_data_o),
        .o_valid     (uart_tx_valid_o),
        .o_full      (w_tx_full),
        .o_near_full (io_buffer_full_o)
    );

    assign mem_rd_data_o = r_rd_data;
    assign halt_o        = r_halt;

endmodule
